hazard_md_ctrl: RTL and testbench
=================================

Name: hazard_md_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage pipeline.
- Decides each cycle whether F/D hold and whether the D→E register loads a bubble. It does this from decoded Tuse/Tnew information in D, E and M.
- Owns the multiply/divide busy sequencer, a down-counter started by the E-stage mult/div instruction, and stalls any D-stage HI/LO user until it finishes.
- Drives the F enable, D enable and the E-register clear input.

Parameters:
- MULT_CYCLES, 5, busy cycles loaded for mult/multu (must be ≥1)
- DIV_CYCLES, 10, busy cycles loaded for div/divu (must be ≥1)
- CNT_W, 4, busy-counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- d_rs_addr  in  5  rs of D-stage instr
- d_rt_addr  in  5  rt of D-stage instr
- d_tuse_rs  in  2  cycles until rs needed; 3 = rs unused
- d_tuse_rt  in  2  cycles until rt needed; 3 = rt unused
- e_wa  in  5  E-stage destination register
- e_we  in  1  E-stage writes GPR
- e_tnew  in  2  cycles until E result available
- m_wa  in  5  M-stage destination register
- m_we  in  1  M-stage writes GPR
- m_tnew  in  2  cycles until M result available
- d_md_use  in  1  D instr is mult/div/mfhi/mflo/mthi/mtlo
- e_md_start  in  1  E instr is mult/multu/div/divu (valid, not bubble)
- e_md_is_div  in  1  1 = div/divu, 0 = mult/multu; qualified by e_md_start
- stall  out  1  hazard present this cycle
- f_en  out  1  PC write enable (= ~stall)
- d_en  out  1  F→D register enable (= ~stall)
- e_clr  out  1  E register loads bubble (instr 0, regWE 0, pc preserved)
- md_busy  out  1  mult/div unit busy
- md_done  out  1  one-cycle pulse on the last busy cycle

Behaviour:
- Only state is cnt[CNT_W-1:0]. All other outputs are combinational from inputs and cnt.
- Reset (clk edge with reset=1): cnt←0. While reset=1, stall=0, e_clr=0, f_en=d_en=1, md_done=0.
- md_busy = (cnt != 0).
- rs data hazard: d_tuse_rs!=3, d_rs_addr!=0, and either condition holds:
  - e_we && e_wa==d_rs_addr && e_tnew>d_tuse_rs
  - m_we && m_wa==d_rs_addr && m_tnew>d_tuse_rs
- rt data hazard: identical form using the rt fields.
- Register $0 never causes a hazard. tnew==tuse does not stall; it is resolved by forwarding.
- md hazard = d_md_use && (md_busy || e_md_start). A HI/LO user directly behind a starting mult/div stalls in the start cycle too.
- stall = rs hazard | rt hazard | md hazard; e_clr = stall; f_en = d_en = ~stall.
- Counter at each clk edge, reset=0:
  - If cnt==0 and e_md_start: cnt←(e_md_is_div ? DIV_CYCLES : MULT_CYCLES).
  - Else if cnt!=0: cnt←cnt-1. An e_md_start while busy is ignored and is a protocol violation; the bench asserts it never occurs.
  - Else cnt holds.
- Latency:
  - busy asserts the cycle after the start edge.
  - Busy lasts exactly MULT_CYCLES or DIV_CYCLES cycles.
  - md_done = (cnt==1), so it coincides with the last busy cycle.
  - A stalled HI/LO user enters E the cycle after cnt reaches 0.
- Simultaneous hazards: stall is a plain OR. A single e_clr bubble is inserted per stalled cycle, so no extra cycles are inserted when hazards overlap.
- Reset mid-busy: cnt cleared at that edge. md_busy=0 the following cycle, with no md_done pulse.
- e_clr and an E-register reset coinciding: E-register reset takes precedence. That is the E register's concern; this block does not gate it.

Decomposition:
- Shared package/header holds:
  - TUSE_NONE=2'd3
  - MD_CNT_W
  - default MULT_CYCLES/DIV_CYCLES
  - the opcode/funct constants the decoder uses to drive d_md_use/e_md_start
- One sub-module: md_busy_cnt (counter, md_busy, md_done).
- Hazard comparators stay inline in hazard_md_ctrl.

Test Plan:
- Load-use: E lw writing $8 (e_tnew=2), D addu using $8 (d_tuse_rs=1) → stall=1, e_clr=1, f_en=d_en=0. Next cycle with M lw $8 (m_tnew=1) → stall=0.
- $0 / tnew==tuse: e_wa=0, e_tnew=2, d_rs_addr=0 → stall=0. e_wa=$9, e_tnew=1, d_tuse_rt=1, d_rt_addr=$9 → stall=0.
- Mult then mflo: e_md_start=1, e_md_is_div=0, d_md_use=1 → stall from the start cycle; md_busy high 5 cycles; md_done in busy cycle 5; stall drops the cycle after.
- Div duration: e_md_start=1, e_md_is_div=1, d_md_use=0 → md_busy high exactly 10 cycles, stall=0 throughout, single md_done pulse.
- Reset mid-busy: start div, assert reset at busy cycle 4 → md_busy=0 next cycle, no md_done, stall=0 during reset.
- Combined: md busy and rt data hazard together → stall=1 for max of both durations, with e_clr asserted once per cycle.

Source files
------------

// File: rtl/hazard_md_ctrl_pkg.sv
// Shared constants for the hazard/mult-div controller and the decoder that feeds it.
// Holds Tuse encoding, mult/div timing defaults, MIPS opcode/funct codes and helpers.
package hazard_md_ctrl_pkg;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam int MD_CNT_W         = 4;
  localparam int MULT_CYCLES_DEF  = 5;
  localparam int DIV_CYCLES_DEF   = 10;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1a;
  localparam logic [5:0] FN_DIVU    = 6'h1b;

  // Decoder helpers: which SPECIAL instructions start the unit or touch HI/LO.
  function automatic logic is_md_start(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_SPECIAL) &&
           (fn == FN_MULT || fn == FN_MULTU || fn == FN_DIV || fn == FN_DIVU);
  endfunction

  function automatic logic is_md_div(input logic [5:0] fn);
    return (fn == FN_DIV) || (fn == FN_DIVU);
  endfunction

  function automatic logic is_md_use(input logic [5:0] op, input logic [5:0] fn);
    return is_md_start(op, fn) ||
           ((op == OP_SPECIAL) &&
            (fn == FN_MFHI || fn == FN_MTHI || fn == FN_MFLO || fn == FN_MTLO));
  endfunction

  // A source operand must wait when a younger-stage producer is still too far from done.
  function automatic logic src_hazard(input logic [4:0] d_addr, input logic [1:0] tuse,
                                      input logic [4:0] wa, input logic we,
                                      input logic [1:0] tnew);
    return (tuse != TUSE_NONE) && (d_addr != 5'd0) && we && (wa == d_addr) && (tnew > tuse);
  endfunction

endpackage

// File: rtl/hazard_md_ctrl_if.sv
// Pipeline <-> hazard controller bundle: decoded D/E/M hazard info in, stall controls out.
interface hazard_md_ctrl_if;
  logic [4:0] d_rs_addr;
  logic [4:0] d_rt_addr;
  logic [1:0] d_tuse_rs;
  logic [1:0] d_tuse_rt;
  logic [4:0] e_wa;
  logic       e_we;
  logic [1:0] e_tnew;
  logic [4:0] m_wa;
  logic       m_we;
  logic [1:0] m_tnew;
  logic       d_md_use;
  logic       e_md_start;
  logic       e_md_is_div;
  logic       stall;
  logic       f_en;
  logic       d_en;
  logic       e_clr;
  logic       md_busy;
  logic       md_done;

  modport master (
    output d_rs_addr, d_rt_addr, d_tuse_rs, d_tuse_rt,
           e_wa, e_we, e_tnew, m_wa, m_we, m_tnew,
           d_md_use, e_md_start, e_md_is_div,
    input  stall, f_en, d_en, e_clr, md_busy, md_done
  );

  modport slave (
    input  d_rs_addr, d_rt_addr, d_tuse_rs, d_tuse_rt,
           e_wa, e_we, e_tnew, m_wa, m_we, m_tnew,
           d_md_use, e_md_start, e_md_is_div,
    output stall, f_en, d_en, e_clr, md_busy, md_done
  );
endinterface

// File: rtl/hazard_md_ctrl_md_busy_cnt.sv
// Mult/div busy sequencer: down-counter loaded by an E-stage mult/div start.
// busy while non-zero; done marks the final busy cycle.
module md_busy_cnt #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic is_div_i,
  output logic busy_o,
  output logic done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A start arriving while busy is a protocol violation and is deliberately dropped.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q == '0) begin
      if (start_i) cnt_d = is_div_i ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: state updates use <= so every register samples pre-edge values; reset is synchronous.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != '0);
  assign done_o = (cnt_q == CNT_W'(1)) && !reset;

endmodule

// File: rtl/hazard_md_ctrl.sv
// Pipeline hazard controller: RAW stalls from Tuse/Tnew plus HI/LO interlock on the
// mult/div busy sequencer. Drives F/D enables and the E-register bubble.
module hazard_md_ctrl
  import hazard_md_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = MD_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  hazard_md_ctrl_if.slave  hz
);

  logic md_busy;
  logic md_done;
  logic rs_hazard;
  logic rt_hazard;
  logic md_hazard;
  logic stall;

  md_busy_cnt #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_cnt (
    .clk      (clk),
    .reset    (reset),
    .start_i  (hz.e_md_start),
    .is_div_i (hz.e_md_is_div),
    .busy_o   (md_busy),
    .done_o   (md_done)
  );

  assign rs_hazard =
      src_hazard(hz.d_rs_addr, hz.d_tuse_rs, hz.e_wa, hz.e_we, hz.e_tnew) ||
      src_hazard(hz.d_rs_addr, hz.d_tuse_rs, hz.m_wa, hz.m_we, hz.m_tnew);
  assign rt_hazard =
      src_hazard(hz.d_rt_addr, hz.d_tuse_rt, hz.e_wa, hz.e_we, hz.e_tnew) ||
      src_hazard(hz.d_rt_addr, hz.d_tuse_rt, hz.m_wa, hz.m_we, hz.m_tnew);

  // Covering the start cycle keeps a HI/LO user from slipping past a mult/div entering E.
  assign md_hazard = hz.d_md_use && (md_busy || hz.e_md_start);

  assign stall = (rs_hazard || rt_hazard || md_hazard) && !reset;

  assign hz.stall   = stall;
  assign hz.e_clr   = stall;
  assign hz.f_en    = !stall;
  assign hz.d_en    = !stall;
  assign hz.md_busy = md_busy;
  assign hz.md_done = md_done;

endmodule

// File: tb/tb_hazard_md_ctrl.sv
// Directed self-checking bench for hazard_md_ctrl: data hazards, mult/div interlock,
// busy durations, reset mid-busy and overlapping hazards.
module tb_hazard_md_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  hazard_md_ctrl_if hz ();

  hazard_md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  // Protocol: a new mult/div must never enter E while the unit is busy.
  always @(negedge clk) begin
    if (!reset && hz.md_busy && hz.e_md_start) begin
      fails++;
      $error("FAIL md_start_while_busy: got start=1 busy=1 expected start=0");
    end
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Checks every output; e_clr/f_en/d_en derive from the expected stall.
  task automatic chk_all(input string tag, input logic st, input logic busy, input logic done);
    chk({tag, ".stall"},   hz.stall,   st);
    chk({tag, ".e_clr"},   hz.e_clr,   st);
    chk({tag, ".f_en"},    hz.f_en,    !st);
    chk({tag, ".d_en"},    hz.d_en,    !st);
    chk({tag, ".md_busy"}, hz.md_busy, busy);
    chk({tag, ".md_done"}, hz.md_done, done);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hz.d_rs_addr = 5'd0;  hz.d_rt_addr = 5'd0;
    hz.d_tuse_rs = 2'd3;  hz.d_tuse_rt = 2'd3;
    hz.e_wa = 5'd0; hz.e_we = 1'b0; hz.e_tnew = 2'd0;
    hz.m_wa = 5'd0; hz.m_we = 1'b0; hz.m_tnew = 2'd0;
    hz.d_md_use = 1'b0; hz.e_md_start = 1'b0; hz.e_md_is_div = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    next_cyc();
    next_cyc();

    // Reset holds outputs quiet even with a load-use hazard present.
    hz.e_we = 1'b1; hz.e_wa = 5'd8; hz.e_tnew = 2'd2;
    hz.d_rs_addr = 5'd8; hz.d_tuse_rs = 2'd1; hz.d_md_use = 1'b1;
    #1 chk_all("reset", 1'b0, 1'b0, 1'b0);
    next_cyc();
    reset = 1'b0;
    idle_inputs();

    // Load-use on rs via E, then resolved once lw reaches M with tnew=1.
    hz.e_we = 1'b1; hz.e_wa = 5'd8; hz.e_tnew = 2'd2;
    hz.d_rs_addr = 5'd8; hz.d_tuse_rs = 2'd1;
    #1 chk_all("load_use", 1'b1, 1'b0, 1'b0);
    next_cyc();
    hz.e_we = 1'b0; hz.e_wa = 5'd0; hz.e_tnew = 2'd0;
    hz.m_we = 1'b1; hz.m_wa = 5'd8; hz.m_tnew = 2'd1;
    #1 chk("load_use_m_tnew1", hz.stall, 1'b0);
    hz.m_tnew = 2'd2;
    #1 chk("m_stage_rs_hazard", hz.stall, 1'b1);
    hz.d_tuse_rs = 2'd3;
    #1 chk("rs_unused", hz.stall, 1'b0);
    idle_inputs();

    // rt hazard from E, and a non-writing producer.
    hz.e_we = 1'b1; hz.e_wa = 5'd9; hz.e_tnew = 2'd2;
    hz.d_rt_addr = 5'd9; hz.d_tuse_rt = 2'd0;
    #1 chk("rt_hazard_e", hz.stall, 1'b1);
    hz.e_we = 1'b0;
    #1 chk("rt_no_we", hz.stall, 1'b0);
    hz.e_we = 1'b1; hz.e_wa = 5'd10;
    #1 chk("rt_addr_mismatch", hz.stall, 1'b0);
    idle_inputs();

    // $0 never hazards; tnew==tuse is forwarded.
    hz.e_we = 1'b1; hz.e_wa = 5'd0; hz.e_tnew = 2'd2;
    hz.d_rs_addr = 5'd0; hz.d_tuse_rs = 2'd0;
    #1 chk("reg_zero", hz.stall, 1'b0);
    hz.e_wa = 5'd9; hz.e_tnew = 2'd1;
    hz.d_rs_addr = 5'd0; hz.d_tuse_rs = 2'd3;
    hz.d_rt_addr = 5'd9; hz.d_tuse_rt = 2'd1;
    #1 chk("tnew_eq_tuse", hz.stall, 1'b0);
    idle_inputs();
    next_cyc();

    // mult followed by mflo: stalls in the start cycle and for 5 busy cycles.
    hz.e_md_start = 1'b1; hz.e_md_is_div = 1'b0; hz.d_md_use = 1'b1;
    #1 chk_all("mult_start", 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      next_cyc();
      hz.e_md_start = 1'b0;
      #1 chk_all($sformatf("mult_busy%0d", i), 1'b1, 1'b1, (i == 5));
    end
    next_cyc();
    #1 chk_all("mult_after", 1'b0, 1'b0, 1'b0);
    idle_inputs();

    // div with no HI/LO user: 10 busy cycles, no stall, exactly one done pulse.
    begin
      int busy_cnt = 0;
      int done_cnt = 0;
      hz.e_md_start = 1'b1; hz.e_md_is_div = 1'b1;
      #1 chk_all("div_start", 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 12; i++) begin
        next_cyc();
        hz.e_md_start = 1'b0; hz.e_md_is_div = 1'b0;
        #1;
        if (hz.md_busy === 1'b1) busy_cnt++;
        if (hz.md_done === 1'b1) done_cnt++;
        chk($sformatf("div_nostall%0d", i), hz.stall, 1'b0);
        if (i == 10) chk("div_done_last", hz.md_done, 1'b1);
      end
      tests++;
      assert (busy_cnt === 10) else begin
        fails++;
        $error("FAIL div_busy_len: got %0d expected %0d", busy_cnt, 10);
      end
      tests++;
      assert (done_cnt === 1) else begin
        fails++;
        $error("FAIL div_done_count: got %0d expected %0d", done_cnt, 1);
      end
    end

    // Reset at div busy cycle 4: no done pulse, busy clears after the edge.
    hz.e_md_start = 1'b1; hz.e_md_is_div = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      next_cyc();
      hz.e_md_start = 1'b0; hz.e_md_is_div = 1'b0;
      #1 chk_all($sformatf("rst_div_busy%0d", i), 1'b0, 1'b1, 1'b0);
    end
    next_cyc();
    reset = 1'b1; hz.d_md_use = 1'b1;
    #1 chk_all("rst_mid_busy", 1'b0, 1'b1, 1'b0);
    next_cyc();
    #1 chk_all("rst_after_edge", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #1 chk("post_rst_mduse", hz.stall, 1'b0);
    idle_inputs();
    next_cyc();

    // Reset landing on the last busy cycle suppresses md_done.
    hz.e_md_start = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      next_cyc();
      hz.e_md_start = 1'b0;
    end
    reset = 1'b1;
    #1 chk_all("rst_on_done", 1'b0, 1'b1, 1'b0);
    next_cyc();
    reset = 1'b0;
    #1 chk("rst_on_done_clear", hz.md_busy, 1'b0);
    next_cyc();

    // Overlap: md interlock and rt hazard together, then rt hazard outlives busy.
    hz.e_md_start = 1'b1; hz.d_md_use = 1'b1;
    hz.e_we = 1'b1; hz.e_wa = 5'd10; hz.e_tnew = 2'd2;
    hz.d_rt_addr = 5'd10; hz.d_tuse_rt = 2'd0;
    #1 chk_all("comb_start", 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      next_cyc();
      hz.e_md_start = 1'b0;
      if (i == 3) begin
        hz.e_we = 1'b0; hz.e_wa = 5'd0; hz.e_tnew = 2'd0;
      end
      #1 chk_all($sformatf("comb_busy%0d", i), 1'b1, 1'b1, (i == 5));
    end
    next_cyc();
    hz.d_md_use = 1'b0;
    hz.m_we = 1'b1; hz.m_wa = 5'd10; hz.m_tnew = 2'd1;
    #1 chk_all("comb_rt_only", 1'b1, 1'b0, 1'b0);
    next_cyc();
    idle_inputs();
    #1 chk_all("comb_clear", 1'b0, 1'b0, 1'b0);

    next_cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard time bound so the bench never hangs.
  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
